bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arb_pkg.sv | 18 +
 rtl/rr_pick2.sv | 19 +
 rtl/bus_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_arb_pkg
// Brief   : Shared FSM state encoding and defaults for the system-bus arbiter.
// Revision: 1.0
// ============================================================================
package bus_arb_pkg;

    localparam int c_BEATS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : bus_arb_pkg
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick2
// Brief   : Two-way round-robin pick; a tie goes to the side not granted last.
// Revision: 1.0
// ============================================================================
module rr_pick2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_grant,
    output logic o_valid
);

    assign o_valid = i_req0 | i_req1;
    assign o_grant = (i_req0 & i_req1) ? ~i_last_grant : i_req1;

endmodule : rr_pick2
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bus_arbiter
// Brief   : Two-requester arbiter; one outstanding line fill on the system bus.
// Revision: 1.0
// ============================================================================
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = c_BEATS_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m0_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m0_req,
    input  logic [BUS_TAG_WIDTH-1:0]  m0_reqtag,
    output logic                      m0_reqack,
    output logic                      m0_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] m0_resp,
    output logic [BUS_TAG_WIDTH-1:0]  m0_resptag,
    input  logic                      m0_respack,
    input  logic                      m1_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m1_req,
    input  logic [BUS_TAG_WIDTH-1:0]  m1_reqtag,
    output logic                      m1_reqack,
    output logic                      m1_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] m1_resp,
    output logic [BUS_TAG_WIDTH-1:0]  m1_resptag,
    input  logic                      m1_respack,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);

    localparam int                 c_CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(BEATS - 1);

    state_t                      r_state;
    state_t                      w_next_state;
    logic                        r_grant;
    logic                        r_last_grant;
    logic [BUS_DATA_WIDTH-1:0]   r_bus_req;
    logic [BUS_TAG_WIDTH-1:0]    r_bus_reqtag;
    logic [c_CNT_W-1:0]          r_beat;
    logic                        w_pick_grant;
    logic                        w_pick_valid;
    logic                        w_in_req;
    logic                        w_in_resp;
    logic                        w_g_respack;
    logic                        w_beat_xfer;
    logic                        w_last_xfer;

    rr_pick2 u_rr_pick2 (
        .i_req0       (m0_reqcyc),
        .i_req1       (m1_reqcyc),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick_grant),
        .o_valid      (w_pick_valid)
    );

    assign w_in_req    = (r_state == REQ);
    assign w_in_resp   = (r_state == RESP);
    assign w_g_respack = r_grant ? m1_respack : m0_respack;
    assign w_beat_xfer = w_in_resp & bus_respcyc & w_g_respack;
    assign w_last_xfer = w_beat_xfer & (r_beat == c_LAST_BEAT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_bus_req    <= '0;
            r_bus_reqtag <= '0;
            r_beat       <= '0;
        end else begin
            r_state <= w_next_state;
            // Address/tag are captured once; later requester changes are ignored.
            if ((r_state == IDLE) && w_pick_valid) begin
                r_grant      <= w_pick_grant;
                r_bus_req    <= w_pick_grant ? m1_req    : m0_req;
                r_bus_reqtag <= w_pick_grant ? m1_reqtag : m0_reqtag;
            end
            if (w_beat_xfer) begin
                r_beat <= w_last_xfer ? '0 : r_beat + 1'b1;
            end
            if (w_last_xfer) begin
                r_last_grant <= r_grant;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_pick_valid) w_next_state = REQ;
            REQ:     if (bus_reqack)   w_next_state = RESP;
            RESP:    if (w_last_xfer)  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign bus_reqcyc  = w_in_req;
    assign bus_req     = r_bus_req;
    assign bus_reqtag  = r_bus_reqtag;
    assign bus_respack = w_in_resp & w_g_respack;

    // Response path is steered only to the granted requester while in RESP.
    always_comb begin
        m0_reqack  = 1'b0;
        m1_reqack  = 1'b0;
        m0_respcyc = 1'b0;
        m1_respcyc = 1'b0;
        m0_resp    = '0;
        m1_resp    = '0;
        m0_resptag = '0;
        m1_resptag = '0;
        if (w_in_req) begin
            m0_reqack = bus_reqack & ~r_grant;
            m1_reqack = bus_reqack &  r_grant;
        end
        if (w_in_resp) begin
            if (r_grant) begin
                m1_respcyc = bus_respcyc;
                m1_resp    = bus_resp;
                m1_resptag = bus_resptag;
            end else begin
                m0_respcyc = bus_respcyc;
                m0_resp    = bus_resp;
                m0_resptag = bus_resptag;
            end
        end
    end

endmodule : bus_arbiter
`default_nettype wire
